alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 29 ++
 rtl/result_history.sv | 53 +++++
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_arbiter_pkg
// Description : Opcode constants and FSM state encoding shared by the
//               ALU arbiter and the ALU it drives.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  // ALU operation codes
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Arbiter FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_REPORT  = 2'd3;

  // True for the only operation that produces a remainder and a legality flag
  function automatic logic is_div(input logic [1:0] op);
    return op == OP_DIV;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_history.sv
`default_nettype none
// ============================================================================
// Module      : result_history
// Description : Circular buffer of completed results with a recall pointer
//               that walks back from the newest entry; registered read-out.
// Revision    : 1.0 - initial release
// ============================================================================
module result_history #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_recall,
  output logic [WIDTH-1:0] o_data
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [WIDTH-1:0]   r_data;
  logic [c_PTR_W-1:0] w_rprev;

  // DEPTH is a power of two, so plain pointer arithmetic wraps modulo DEPTH
  assign w_rprev = r_rptr - c_PTR_W'(1);
  assign o_data  = r_data;

  // Write wins over recall; a write also re-points recall at the newest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_data <= '0;
    end else if (i_wr) begin
      r_mem[r_wptr] <= i_wr_data;
      r_rptr        <= r_wptr;
      r_wptr        <= r_wptr + c_PTR_W'(1);
      r_data        <= i_wr_data;
    end else if (i_recall) begin
      r_rptr <= w_rprev;
      r_data <= r_mem[w_rprev];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one registered-output ALU between
//               two requesters; captures result/remainder/error, pulses done
//               and logs each result into a recallable history buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int HIST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_rem,
  input  logic        alu_div_flag,
  output logic        done,
  output logic        owner,
  output logic [15:0] res_out,
  output logic [3:0]  rem_out,
  output logic        err,
  output logic        busy,
  input  logic        recall,
  output logic [15:0] hist_out
);

  state_t      r_state;
  state_t      w_next;
  logic        r_prio;      // requester favoured on the next contested grant
  logic        r_gnt0;
  logic        r_gnt1;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [1:0]  r_alu_op;
  logic        r_done;
  logic        r_owner;
  logic [15:0] r_res;
  logic [3:0]  r_rem;
  logic        r_err;
  logic        w_grant;
  logic        w_sel;
  logic        w_capture;
  logic        w_report;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: fixed three-cycle walk once a request is accepted
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (req0 || req1) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_REPORT;
      ST_REPORT:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Control strobes; a lone request always wins, a contested one goes to r_prio
  always_comb begin
    w_grant   = (r_state == ST_IDLE) && (req0 || req1);
    w_sel     = (req0 && req1) ? r_prio : req1;
    w_capture = (r_state == ST_CAPTURE);
    w_report  = (r_state == ST_REPORT);
  end

  // Registered grant, ALU operand, capture and report datapath.
  // Priority only moves on contested grants, so alternation between two
  // simultaneously requesting masters is not disturbed by solo traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio   <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_owner  <= 1'b0;
      r_done   <= 1'b0;
      r_res    <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_gnt0 <= w_grant && !w_sel;
      r_gnt1 <= w_grant && w_sel;
      r_done <= w_report;
      if (w_grant) begin
        r_alu_a  <= w_sel ? a1  : a0;
        r_alu_b  <= w_sel ? b1  : b0;
        r_alu_op <= w_sel ? op1 : op0;
        r_owner  <= w_sel;
        if (req0 && req1) begin
          r_prio <= ~w_sel;
        end
      end
      if (w_capture) begin
        r_res <= alu_result;
        if (is_div(r_alu_op)) begin
          r_rem <= alu_rem;
          r_err <= ~alu_div_flag;
        end else begin
          r_rem <= '0;
          r_err <= 1'b0;
        end
      end
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_op  = r_alu_op;
  assign done    = r_done;
  assign owner   = r_owner;
  assign res_out = r_res;
  assign rem_out = r_rem;
  assign err     = r_err;
  assign busy    = (r_state != ST_IDLE);

  result_history #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (16)
  ) u_result_history (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_report),
    .i_wr_data (r_res),
    .i_recall  (recall),
    .o_data    (hist_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a bench-side ALU and
//               a transaction-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int HD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result = '0;
  logic [3:0]  alu_rem = '0;
  logic        alu_div_flag = 1'b0;
  logic        done, owner, err, busy;
  logic [15:0] res_out, hist_out;
  logic [3:0]  rem_out;
  logic        recall = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int tcyc  = 0;
  bit chk_en = 1'b0;

  alu_arbiter #(.HIST_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_rem(alu_rem), .alu_div_flag(alu_div_flag), .done(done), .owner(owner),
    .res_out(res_out), .rem_out(rem_out), .err(err), .busy(busy),
    .recall(recall), .hist_out(hist_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tcyc <= tcyc + 1;

  // Bench ALU: registered, result valid one cycle after its inputs change.
  // Non-divide ops drive junk remainder/flag so the arbiter must mask them.
  always @(posedge clk) begin : alu_model
    logic lg;
    lg = (alu_a < 8'd16) && (alu_b < 8'd16) && (alu_b != 8'd0);
    case (alu_op)
      2'b00:   alu_result <= 16'(alu_a) + 16'(alu_b);
      2'b01:   alu_result <= 16'(alu_a) - 16'(alu_b);
      2'b10:   alu_result <= 16'(alu_a) * 16'(alu_b);
      default: alu_result <= lg ? 16'(alu_a / alu_b) : 16'h0000;
    endcase
    if (alu_op == 2'b11) begin
      alu_rem      <= lg ? 4'(alu_a % alu_b) : 4'h0;
      alu_div_flag <= lg;
    end else begin
      alu_rem      <= alu_a[3:0] ^ alu_b[3:0];
      alu_div_flag <= alu_a[0];
    end
  end

  // Expected {err, rem, res} of one operation from plain integer arithmetic
  function automatic logic [20:0] expect_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r, rm;
    logic e;
    ia = int'(a); ib = int'(b); r = 0; rm = 0; e = 1'b0;
    case (op)
      2'd0: r = (ia + ib) % 65536;
      2'd1: r = (ia - ib + 65536) % 65536;
      2'd2: r = ia * ib;
      default: begin
        if (ia > 15 || ib > 15 || ib == 0) e = 1'b1;
        else begin r = ia / ib; rm = ia % ib; end
      end
    endcase
    return {e, 4'(rm), 16'(r)};
  endfunction

  // ---------------- reference model (transaction timeline) ----------------
  int          m_age  = 100;   // cycles since the last grant (saturating)
  logic        m_prio = 1'b0;
  logic        m_gnt0 = 1'b0, m_gnt1 = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  logic [7:0]  m_a = '0, m_b = '0;
  logic [1:0]  m_op = '0;
  logic        m_owner = 1'b0;
  logic [15:0] m_res = '0, p_res = '0;
  logic [3:0]  m_rem = '0, p_rem = '0;
  logic        m_err = 1'b0, p_err = 1'b0;
  logic [15:0] m_hist [HD];
  int          m_wp = 0, m_rp = 0;
  logic [15:0] m_hout = '0;

  always @(posedge clk or posedge rst) begin
    logic        win;
    logic [20:0] x;
    if (rst) begin
      m_age = 100; m_prio = 1'b0;
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_done = 1'b0; m_busy = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_owner = 1'b0;
      m_res = '0; m_rem = '0; m_err = 1'b0;
      for (int i = 0; i < HD; i++) m_hist[i] = '0;
      m_wp = 0; m_rp = 0; m_hout = '0;
    end else begin
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_done = 1'b0;
      if (m_age < 100) m_age = m_age + 1;
      if (m_age == 2) begin
        m_res = p_res; m_rem = p_rem; m_err = p_err;
      end
      if (m_age == 3) begin
        m_done = 1'b1;
        m_hist[m_wp] = m_res; m_rp = m_wp; m_hout = m_res;
        m_wp = (m_wp + 1) % HD;
      end else if (recall) begin
        m_rp = (m_rp + HD - 1) % HD;
        m_hout = m_hist[m_rp];
      end
      if (m_age >= 4 && (req0 || req1)) begin
        if (req0 && req1) begin
          win = m_prio;
          m_prio = ~win;
        end else begin
          win = req1;
        end
        m_age = 0; m_owner = win;
        if (win) begin m_gnt1 = 1'b1; m_a = a1; m_b = b1; m_op = op1; end
        else     begin m_gnt0 = 1'b1; m_a = a0; m_b = b0; m_op = op0; end
        x = expect_op(m_op, m_a, m_b);
        p_res = x[15:0]; p_rem = x[19:16]; p_err = x[20];
      end
      m_busy = (m_age <= 2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt0", 32'(gnt0), 32'(m_gnt0));
      chk("gnt1", 32'(gnt1), 32'(m_gnt1));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("res_out", 32'(res_out), 32'(m_res));
      chk("rem_out", 32'(rem_out), 32'(m_rem));
      chk("err", 32'(err), 32'(m_err));
      chk("hist_out", 32'(hist_out), 32'(m_hout));
    end
  end

  // ---------------- directed helpers ----------------
  logic        q_own [$];
  logic [15:0] q_res [$];
  logic [3:0]  q_rem [$];
  logic        q_err [$];
  int          first_lat;

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; recall = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run(input logic r0, input logic [1:0] o0, input logic [7:0] x0, input logic [7:0] y0,
                     input logic r1, input logic [1:0] o1, input logic [7:0] x1, input logic [7:0] y1);
    int need, nd, tg;
    q_own.delete(); q_res.delete(); q_rem.delete(); q_err.delete();
    need = int'(r0) + int'(r1); nd = 0; tg = -1; first_lat = -1;
    op0 = o0; a0 = x0; b0 = y0; op1 = o1; a1 = x1; b1 = y1;
    req0 = r0; req1 = r1;
    for (int k = 0; k < 60 && nd < need; k++) begin
      @(negedge clk);
      if ((gnt0 || gnt1) && tg < 0) tg = tcyc;
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (done) begin
        if (nd == 0) first_lat = tcyc - tg;
        q_own.push_back(owner); q_res.push_back(res_out);
        q_rem.push_back(rem_out); q_err.push_back(err);
        nd++;
      end
    end
    if (nd < need) begin
      n_cmp++; n_err++;
      $display("FAIL run_timeout: got %0d done pulses expected %0d", nd, need);
      for (int k = nd; k < need; k++) begin
        q_own.push_back(1'bx); q_res.push_back('x); q_rem.push_back('x); q_err.push_back(1'bx);
      end
    end
  endtask

  task automatic pulse_recall(input logic [15:0] exp, input string name);
    @(negedge clk); recall = 1'b1;
    @(negedge clk); recall = 1'b0;
    chk(name, 32'(hist_out), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    // reset state pins
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", 32'(res_out), 32'd0);
    chk("rst_hist", 32'(hist_out), 32'd0);
    chk("rst_gnt0", 32'(gnt0), 32'd0);

    // single add 5+7
    run(1'b1, 2'b00, 8'd5, 8'd7, 1'b0, 2'b00, 8'd0, 8'd0);
    chk("add_latency", 32'(first_lat), 32'd3);
    chk("add_res", 32'(q_res[0]), 32'd12);
    chk("add_owner", 32'(q_own[0]), 32'd0);
    chk("add_err", 32'(q_err[0]), 32'd0);

    // contested pair from reset priority, then a repeat
    do_reset();
    run(1'b1, 2'b10, 8'd3, 8'd4, 1'b1, 2'b01, 8'd9, 8'd2);
    chk("rr1_first_owner", 32'(q_own[0]), 32'd0);
    chk("rr1_first_res", 32'(q_res[0]), 32'd12);
    chk("rr1_second_owner", 32'(q_own[1]), 32'd1);
    chk("rr1_second_res", 32'(q_res[1]), 32'd7);
    run(1'b1, 2'b10, 8'd3, 8'd4, 1'b1, 2'b01, 8'd9, 8'd2);
    chk("rr2_first_owner", 32'(q_own[0]), 32'd1);
    chk("rr2_first_res", 32'(q_res[0]), 32'd7);

    // divide legal and by zero
    run(1'b1, 2'b11, 8'd13, 8'd4, 1'b0, 2'b00, 8'd0, 8'd0);
    chk("div_res", 32'(q_res[0]), 32'd3);
    chk("div_rem", 32'(q_rem[0]), 32'd1);
    chk("div_err", 32'(q_err[0]), 32'd0);
    run(1'b1, 2'b11, 8'd13, 8'd0, 1'b0, 2'b00, 8'd0, 8'd0);
    chk("div0_res", 32'(q_res[0]), 32'd0);
    chk("div0_rem", 32'(q_rem[0]), 32'd0);
    chk("div0_err", 32'(q_err[0]), 32'd1);

    // history wrap-around and recall
    do_reset();
    for (int k = 1; k <= 5; k++) run(1'b1, 2'b00, 8'(k), 8'd0, 1'b0, 2'b00, 8'd0, 8'd0);
    chk("hist_newest", 32'(hist_out), 32'd5);
    pulse_recall(16'd4, "recall1");
    pulse_recall(16'd3, "recall2");
    pulse_recall(16'd2, "recall3");
    pulse_recall(16'd5, "recall_wrap");
    pulse_recall(16'd4, "recall5");
    // recall coinciding with the history write
    op0 = 2'b00; a0 = 8'd9; b0 = 8'd0; req0 = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge clk);
      if (gnt0) begin req0 = 1'b0; got = 1; end
    end
    chk("collide_gnt", 32'(got), 32'd1);
    @(negedge clk);
    @(negedge clk); recall = 1'b1;
    @(negedge clk); recall = 1'b0;
    chk("collide_done", 32'(done), 32'd1);
    chk("collide_hist", 32'(hist_out), 32'd9);
    pulse_recall(16'd5, "after_collide");

    // reset while in CAPTURE
    op0 = 2'b00; a0 = 8'd20; b0 = 8'd30; req0 = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge clk);
      if (gnt0) begin req0 = 1'b0; got = 1; end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstcap_busy", 32'(busy), 32'd0);
    chk("rstcap_alu_a", 32'(alu_a), 32'd0);
    chk("rstcap_res", 32'(res_out), 32'd0);
    chk("rstcap_hist", 32'(hist_out), 32'd0);
    got = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("rstcap_no_done", 32'(got), 32'd0);
    #2 rst = 1'b0;
    run(1'b1, 2'b00, 8'd20, 8'd30, 1'b0, 2'b00, 8'd0, 8'd0);
    chk("post_rst_res", 32'(q_res[0]), 32'd50);

    // randomized traffic, recall pulses and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        op0 = 2'($urandom);
        a0 = (op0 == 2'b11 && $urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        b0 = (op0 == 2'b11 && $urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        req0 = 1'b1;
      end
      if (gnt1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        op1 = 2'($urandom);
        a1 = (op1 == 2'b11 && $urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        b1 = (op1 == 2'b11 && $urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        req1 = 1'b1;
      end
      recall = ($urandom_range(0, 5) == 0);
      if (c % 900 == 450) begin
        #2;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; recall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0; recall = 1'b0;
    repeat (6) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
